// File: rtl/ksa_pkg.sv
// Shared types and sizing helpers for the pipelined Kogge-Stone adder.
package ksa_pkg;

    // One prefix-tree node: group generate / group propagate.
    typedef struct packed {
        logic g;
        logic p;
    } ksa_gp_t;

    function automatic int ksa_levels(input int width);
        return $clog2(width);
    endfunction

    function automatic int ksa_latency(input int width, input int reg_every);
        return (ksa_levels(width) + reg_every - 1) / reg_every + 1;
    endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone level over the (WIDTH+1)-entry prefix vector.
module ksa_prefix_level
    import ksa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  ksa_gp_t [WIDTH:0] prv,
    output ksa_gp_t [WIDTH:0] nxt
);

    // Entry 0 is the carry-in node; entries below DIST pass through.
    always_comb begin
        nxt = prv;
        for (int j = DIST; j <= WIDTH; j++) begin
            nxt[j].g = prv[j].g | (prv[j].p & prv[j-DIST].g);
            nxt[j].p = prv[j].p & prv[j-DIST].p;
        end
    end

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a global-enable valid/ready pipeline.
module ksa_pipe_adder
    import ksa_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS  = ksa_levels(WIDTH);
    localparam int LATENCY = ksa_latency(WIDTH, REG_EVERY);

    typedef ksa_gp_t [WIDTH:0] gp_vec_t;

    logic               adv;
    logic [LATENCY:1]   vld_pipe;

    assign out_valid = vld_pipe[LATENCY];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe <= '0;
        else if (adv)
            vld_pipe <= {vld_pipe[LATENCY-1:1], in_valid};
    end

    // Pre-process: carry-in becomes prefix entry 0 (g=c_eff, p=0).
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_pre;
    logic             c_eff;
    gp_vec_t          gp_pre;

    always_comb begin
        b_eff     = sub ? ~b : b;
        c_eff     = cin ^ sub;
        p_pre     = a ^ b_eff;
        gp_pre    = '0;
        gp_pre[0] = '{g: c_eff, p: 1'b0};
        for (int i = 0; i < WIDTH; i++)
            gp_pre[i+1] = '{g: a[i] & b_eff[i], p: p_pre[i]};
    end

    gp_vec_t          gp_in_q;
    logic [WIDTH-1:0] p_in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gp_in_q <= '0;
            p_in_q  <= '0;
        end else if (adv) begin
            gp_in_q <= gp_pre;
            p_in_q  <= p_pre;
        end
    end

    // The last level never gets its own slice: it feeds the output register.
    for (genvar k = 0; k < LEVELS; k++) begin : lvl_g
        gp_vec_t          src;
        gp_vec_t          nxt;
        gp_vec_t          gp_q;
        logic [WIDTH-1:0] p_src;
        logic [WIDTH-1:0] p_q;

        if (k == 0) begin : g_src_first
            assign src   = gp_in_q;
            assign p_src = p_in_q;
        end else begin : g_src_prev
            assign src   = lvl_g[k-1].gp_q;
            assign p_src = lvl_g[k-1].p_q;
        end

        ksa_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .prv (src),
            .nxt (nxt)
        );

        if (((k + 1) % REG_EVERY == 0) && (k != LEVELS - 1)) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gp_q <= '0;
                    p_q  <= '0;
                end else if (adv) begin
                    gp_q <= nxt;
                    p_q  <= p_src;
                end
            end
        end else begin : g_comb
            assign gp_q = nxt;
            assign p_q  = p_src;
        end
    end

    gp_vec_t          fin;
    logic [WIDTH-1:0] p_fin;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             unused_fin;

    assign fin        = lvl_g[LEVELS-1].gp_q;
    assign p_fin      = lvl_g[LEVELS-1].p_q;
    assign unused_fin = ^fin;

    // For power-of-two widths the top node spans only bits 0..WIDTH-1, so the
    // carry-in node is folded in once more; the fold is a no-op otherwise (P=0).
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < WIDTH; i++)
            sum_d[i] = p_fin[i] ^ fin[i].g;
        cout_d = fin[WIDTH].g | (fin[WIDTH].p & fin[0].g);
        ovf_d  = fin[WIDTH-1].g ^ cout_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (adv) begin
            sum  <= sum_d;
            cout <= cout_d;
            ovf  <= ovf_d;
        end
    end

endmodule
